// File: rtl/fp_compare_pipe.sv
// Two-stage pipelined IEEE-754 comparator: eq/gt/lt/unordered flags, invalid flag and
// minNum/maxNum results behind a valid/ready handshake with full backpressure.
`timescale 1ns/1ps
module fp_compare_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   eq,
  output logic                   gt,
  output logic                   lt,
  output logic                   unord,
  output logic                   invalid,
  output logic [EXP_W+MAN_W:0]   min_out,
  output logic [EXP_W+MAN_W:0]   max_out
);

  localparam int unsigned W = 1 + EXP_W + MAN_W;
  localparam logic [W-1:0] ALL1     = '1;
  localparam logic [W-1:0] NEG_ZERO = ~(ALL1 >> 1);
  localparam logic [W-1:0] POS_ZERO = '0;
  // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set, rest zero.
  localparam logic [W-1:0] QNAN     = (ALL1 >> 1) & ~(ALL1 >> (EXP_W + 2));

  function automatic logic is_nan(input logic [W-1:0] x);
    return (&x[W-2 -: EXP_W]) && (|x[MAN_W-1:0]);
  endfunction

  function automatic logic is_snan(input logic [W-1:0] x);
    return is_nan(x) && !x[MAN_W-1];
  endfunction

  logic           r_s1_valid;
  logic           r_a_sign, r_b_sign;
  logic           r_a_gt, r_a_eq;
  logic           r_a_nan, r_b_nan, r_a_snan, r_b_snan;
  logic           r_a_zero, r_b_zero;
  logic [W-1:0]   r_a, r_b;

  logic           w_s1_adv, w_s2_adv;
  logic           w_eq, w_gt, w_lt, w_unord, w_invalid;
  logic [W-1:0]   w_min, w_max;

  assign w_s2_adv = !out_valid || out_ready;
  assign w_s1_adv = w_s2_adv || !r_s1_valid;
  assign in_ready = w_s1_adv;

  // Stage 1: operand classification and unsigned magnitude compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_a_sign   <= 1'b0;
      r_b_sign   <= 1'b0;
      r_a_gt     <= 1'b0;
      r_a_eq     <= 1'b0;
      r_a_nan    <= 1'b0;
      r_b_nan    <= 1'b0;
      r_a_snan   <= 1'b0;
      r_b_snan   <= 1'b0;
      r_a_zero   <= 1'b0;
      r_b_zero   <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_a_sign <= a[W-1];
        r_b_sign <= b[W-1];
        r_a_gt   <= a[W-2:0] > b[W-2:0];
        r_a_eq   <= a[W-2:0] == b[W-2:0];
        r_a_nan  <= is_nan(a);
        r_b_nan  <= is_nan(b);
        r_a_snan <= is_snan(a);
        r_b_snan <= is_snan(b);
        r_a_zero <= ~|a[W-2:0];
        r_b_zero <= ~|b[W-2:0];
        r_a      <= a;
        r_b      <= b;
      end
    end
  end

  // Resolve ordering and minNum/maxNum from the stage-1 classification.
  always_comb begin
    w_eq      = 1'b0;
    w_gt      = 1'b0;
    w_lt      = 1'b0;
    w_unord   = 1'b0;
    w_invalid = 1'b0;
    w_min     = r_a;
    w_max     = r_a;
    if (r_a_nan || r_b_nan) begin
      w_unord   = 1'b1;
      w_invalid = r_a_snan || r_b_snan;
      if (r_a_nan && r_b_nan) begin
        w_min = QNAN;
        w_max = QNAN;
      end else if (r_a_nan) begin
        w_min = r_b;
        w_max = r_b;
      end
    end else if (r_a_zero && r_b_zero) begin
      w_eq  = 1'b1;
      w_min = (r_a_sign || r_b_sign) ? NEG_ZERO : POS_ZERO;
      w_max = (r_a_sign && r_b_sign) ? NEG_ZERO : POS_ZERO;
    end else begin
      if (r_a_sign != r_b_sign) begin
        w_lt = r_a_sign;
        w_gt = !r_a_sign;
      end else if (r_a_eq) begin
        w_eq = 1'b1;
      end else begin
        w_gt = r_a_gt ^ r_a_sign;
        w_lt = !w_gt;
      end
      w_min = w_gt ? r_b : r_a;
      w_max = w_gt ? r_a : r_b;
    end
  end

  // Stage 2: registered result drives the outputs; held while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      eq        <= 1'b0;
      gt        <= 1'b0;
      lt        <= 1'b0;
      unord     <= 1'b0;
      invalid   <= 1'b0;
      min_out   <= '0;
      max_out   <= '0;
    end else if (w_s2_adv) begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        eq      <= w_eq;
        gt      <= w_gt;
        lt      <= w_lt;
        unord   <= w_unord;
        invalid <= w_invalid;
        min_out <= w_min;
        max_out <= w_max;
      end
    end
  end

endmodule

// File: tb/tb_fp_compare_pipe.sv
// Bench for fp_compare_pipe: directed IEEE cases, randomized traffic with random
// backpressure against a total-order reference model, stall and reset scenarios.
`timescale 1ns/1ps
module tb_fp_compare_pipe;

  typedef struct packed {
    logic        eq;
    logic        gt;
    logic        lt;
    logic        unord;
    logic        invalid;
    logic [31:0] mn;
    logic [31:0] mx;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, min_out, max_out;
  logic        eq, gt, lt, unord, invalid;
  res_t        obs_now;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   send_done;
  res_t exp_q[$];
  res_t obs_q[$];
  int   obs_cyc[$];

  always #5 clk = ~clk;

  fp_compare_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .eq(eq), .gt(gt), .lt(lt), .unord(unord), .invalid(invalid),
    .min_out(min_out), .max_out(max_out)
  );

  assign obs_now = {eq, gt, lt, unord, invalid, min_out, max_out};

  // Reference: map non-NaN values onto a signed integer line (both zeros -> 0).
  function automatic longint key(input logic [31:0] x);
    longint m;
    m = longint'(x[30:0]);
    return x[31] ? -m : m;
  endfunction

  function automatic bit fnan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
  endfunction

  function automatic res_t model(input logic [31:0] x, input logic [31:0] y);
    res_t   r;
    longint kx, ky;
    r = '0;
    if (fnan(x) || fnan(y)) begin
      r.unord   = 1'b1;
      r.invalid = (fnan(x) && !x[22]) || (fnan(y) && !y[22]);
      if (fnan(x) && fnan(y)) begin r.mn = 32'h7FC00000; r.mx = 32'h7FC00000; end
      else if (fnan(x))       begin r.mn = y; r.mx = y; end
      else                    begin r.mn = x; r.mx = x; end
    end else begin
      kx = key(x);
      ky = key(y);
      if (kx < ky)      begin r.lt = 1'b1; r.mn = x; r.mx = y; end
      else if (kx > ky) begin r.gt = 1'b1; r.mn = y; r.mx = x; end
      else begin
        r.eq = 1'b1;
        if (kx == 0) begin
          r.mn = (x[31] || y[31]) ? 32'h80000000 : 32'h0;
          r.mx = (x[31] && y[31]) ? 32'h80000000 : 32'h0;
        end else begin
          r.mn = x; r.mx = x;
        end
      end
    end
    return r;
  endfunction

  function automatic res_t mk(input logic e, input logic g, input logic l, input logic u,
                              input logic v, input logic [31:0] mn, input logic [31:0] mx);
    return {e, g, l, u, v, mn, mx};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    logic [22:0] m;
    r = $urandom;
    m = (r[22:0] == 23'h0) ? 23'h1 : r[22:0];
    case ($urandom_range(0, 7))
      0, 1, 2: return r;
      3:       return {r[31], 8'h00, r[22:0]};
      4:       return {r[31], 8'hFF, m};
      5:       return {r[31], 31'h0};
      6:       return {r[31], 8'hFF, 23'h0};
      default: return {r[31], 8'h3F, r[22:0]};
    endcase
  endfunction

  // Transfer monitor: expected results enter at input handshakes, observed at output ones.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && in_valid && in_ready) exp_q.push_back(model(a, b));
    if (!rst && out_valid && out_ready) begin
      obs_q.push_back(obs_now);
      obs_cyc.push_back(cyc);
    end
  end

  task automatic clear_q();
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y);
    in_valid = 1'b1;
    a = x;
    b = y;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    n_tests++;
    n_fail++;
    $display("FAIL send_timeout: in_ready stayed 0 for a=%h b=%h, required 1", x, y);
  endtask

  task automatic wait_drain(input int n);
    for (int i = 0; i < 2000 && obs_q.size() < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_tests++;
    if ({out_valid, obs_now} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b res=%h, required all 0", out_valid, obs_now);
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: out_valid got %b, required 0", out_valid);
    end
    clear_q();
  endtask

  task automatic test_directed();
    localparam int N = 14;
    logic [31:0] ta [N];
    logic [31:0] tb_ [N];
    res_t        te [N];
    ta[0]  = 32'h40400000; tb_[0]  = 32'h40000000; te[0]  = mk(0,1,0,0,0, 32'h40000000, 32'h40400000);
    ta[1]  = 32'h80000000; tb_[1]  = 32'h00000000; te[1]  = mk(1,0,0,0,0, 32'h80000000, 32'h00000000);
    ta[2]  = 32'hBF800000; tb_[2]  = 32'hC0000000; te[2]  = mk(0,1,0,0,0, 32'hC0000000, 32'hBF800000);
    ta[3]  = 32'hC0000000; tb_[3]  = 32'hBF800000; te[3]  = mk(0,0,1,0,0, 32'hC0000000, 32'hBF800000);
    ta[4]  = 32'h7FC00000; tb_[4]  = 32'h3F800000; te[4]  = mk(0,0,0,1,0, 32'h3F800000, 32'h3F800000);
    ta[5]  = 32'h7F800001; tb_[5]  = 32'hFFC00000; te[5]  = mk(0,0,0,1,1, 32'h7FC00000, 32'h7FC00000);
    ta[6]  = 32'h00000000; tb_[6]  = 32'h00000000; te[6]  = mk(1,0,0,0,0, 32'h00000000, 32'h00000000);
    ta[7]  = 32'h00000001; tb_[7]  = 32'h00000000; te[7]  = mk(0,1,0,0,0, 32'h00000000, 32'h00000001);
    ta[8]  = 32'h80000001; tb_[8]  = 32'h00000000; te[8]  = mk(0,0,1,0,0, 32'h80000001, 32'h00000000);
    ta[9]  = 32'hFF800000; tb_[9]  = 32'h7F7FFFFF; te[9]  = mk(0,0,1,0,0, 32'hFF800000, 32'h7F7FFFFF);
    ta[10] = 32'h40400000; tb_[10] = 32'h40400000; te[10] = mk(1,0,0,0,0, 32'h40400000, 32'h40400000);
    ta[11] = 32'hBF800000; tb_[11] = 32'h7FA00000; te[11] = mk(0,0,0,1,1, 32'hBF800000, 32'hBF800000);
    ta[12] = 32'h80000000; tb_[12] = 32'h80000000; te[12] = mk(1,0,0,0,0, 32'h80000000, 32'h80000000);
    ta[13] = 32'h00000000; tb_[13] = 32'h80000000; te[13] = mk(1,0,0,0,0, 32'h80000000, 32'h00000000);
    out_ready = 1'b1;
    clear_q();
    for (int i = 0; i < N; i++) send(ta[i], tb_[i]);
    wait_drain(N);
    n_tests++;
    if (obs_q.size() != N) begin
      n_fail++;
      $display("FAIL directed_count: got %0d results, required %0d", obs_q.size(), N);
    end
    for (int i = 0; i < N && i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== te[i]) begin
        n_fail++;
        $display("FAIL directed[%0d] a=%h b=%h: got %h, required %h", i, ta[i], tb_[i], obs_q[i], te[i]);
      end
    end
    // Back-to-back traffic with out_ready high must stream one result per cycle.
    for (int i = 1; i < obs_cyc.size(); i++) begin
      n_tests++;
      if (obs_cyc[i] !== obs_cyc[0] + i) begin
        n_fail++;
        $display("FAIL directed_throughput[%0d]: got cycle %0d, required %0d", i, obs_cyc[i], obs_cyc[0] + i);
      end
    end
    clear_q();
  endtask

  task automatic test_random();
    localparam int N = 400;
    logic [31:0] x, y;
    clear_q();
    send_done = 1'b0;
    fork
      begin
        for (int i = 0; i < N; i++) begin
          x = rand_op();
          case ($urandom_range(0, 5))
            0:       y = x;
            1:       y = x ^ 32'h80000000;
            2:       y = x + 32'h1;
            default: y = rand_op();
          endcase
          if ($urandom_range(0, 1) == 1'b1) send(x, y);
          else                              send(y, x);
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        send_done = 1'b1;
      end
      begin
        while (!send_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain(N);
    n_tests++;
    if (exp_q.size() != N || obs_q.size() != N) begin
      n_fail++;
      $display("FAIL random_count: got %0d in / %0d out, required %0d each", exp_q.size(), obs_q.size(), N);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
      end
    end
    clear_q();
  endtask

  task automatic test_back_to_back_stall();
    logic [31:0] pa [4];
    logic [31:0] pb [4];
    pa[0] = 32'h40400000; pb[0] = 32'h40000000;
    pa[1] = 32'hBF800000; pb[1] = 32'hC0000000;
    pa[2] = 32'h3F800000; pb[2] = 32'h7FC00000;
    pa[3] = 32'h00000001; pb[3] = 32'h80000001;
    out_ready = 1'b0;
    clear_q();
    fork
      begin
        for (int i = 0; i < 4; i++) send(pa[i], pb[i]);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
          n_tests++;
          if (in_ready !== 1'b0 || exp_q.size() != 2) begin
            n_fail++;
            $display("FAIL stall_accept[%0d]: got in_ready=%b accepted=%0d, required 0 and 2", k, in_ready, exp_q.size());
          end
          n_tests++;
          if (out_valid !== 1'b1 || obs_now !== model(pa[0], pb[0])) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: got valid=%b res=%h, required 1 and %h", k, out_valid, obs_now, model(pa[0], pb[0]));
          end
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_drain(4);
    n_tests++;
    if (obs_q.size() != 4) begin
      n_fail++;
      $display("FAIL stall_count: got %0d results, required 4", obs_q.size());
    end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== model(pa[i], pb[i]) || obs_cyc[i] !== obs_cyc[0] + i) begin
        n_fail++;
        $display("FAIL stall_release[%0d]: got %h at +%0d, required %h at +%0d", i, obs_q[i], obs_cyc[i] - obs_cyc[0], model(pa[i], pb[i]), i);
      end
    end
    clear_q();
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    clear_q();
    send(32'h40400000, 32'h40000000);
    send(32'hC0000000, 32'hBF800000);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_tests++;
    if ({out_valid, obs_now} !== '0) begin
      n_fail++;
      $display("FAIL midreset_state: got valid=%b res=%h, required all 0", out_valid, obs_now);
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_in_ready: got %b, required 1", in_ready);
    end
    out_ready = 1'b1;
    clear_q();
    repeat (5) @(posedge clk);
    #1;
    n_tests++;
    if (obs_q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_flush: got %0d stale results valid=%b, required 0 and 0", obs_q.size(), out_valid);
    end
    send(32'h7F800001, 32'h3F800000);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_latency1: out_valid got %b after 1 edge, required 0", out_valid);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b1 || obs_now !== mk(0,0,0,1,1, 32'h3F800000, 32'h3F800000)) begin
      n_fail++;
      $display("FAIL midreset_latency2: got valid=%b res=%h, required 1 and %h", out_valid, obs_now, mk(0,0,0,1,1, 32'h3F800000, 32'h3F800000));
    end
    wait_drain(1);
    clear_q();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back_stall();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
